// File: rtl/booth_mul32.sv
// booth_mul32: sequential signed 32x32 -> 64 multiplier.
// Iterative radix-4 Booth recoding, one recoded digit per clock, 16 steps.
// A 66-bit accumulator absorbs the +/-2M term without overflow; each step
// adds the digit times M into the upper 34 bits, then shifts arithmetic-right
// by two so that after the last step the product sits in acc[63:0].
module booth_mul32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        op_done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_STEP = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] m_q, m_d;
  // Multiplier with the implicit Q[-1] bit appended at position 0.
  logic [32:0] q_q, q_d;
  logic [65:0] acc_q, acc_d;

  // Booth recoding and partial-product formation signals
  logic [2:0]  triplet;
  logic        pp_zero;
  logic        pp_two;
  logic        pp_neg;
  logic [33:0] m_x1;
  logic [33:0] m_x2;
  logic [33:0] pp_mag;
  logic [33:0] pp_add;
  logic [33:0] upper_sum;
  logic signed [65:0] acc_pre;
  logic [65:0] acc_step;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear dominates, start only honoured in IDLE
  always_comb begin
    state_d = state_q;
    if (op_clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (op_start) state_d = S_EXEC;
        S_EXEC: if (cnt_q == LAST_STEP) state_d = S_DONE;
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: done flag from state, result straight from the accumulator
  always_comb begin
    op_done = (state_q == S_DONE);
    result  = acc_q[63:0];
  end

  // Recode the current triplet {Q[2c+1], Q[2c], Q[2c-1]} into a Booth digit
  always_comb begin
    triplet = q_q[{cnt_q, 1'b0} +: 3];
    pp_zero = 1'b0;
    pp_two  = 1'b0;
    pp_neg  = 1'b0;
    case (triplet)
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         pp_two  = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: pp_neg  = 1'b1;
      default:        pp_zero = 1'b1;
    endcase
  end

  // Partial product: select 0/M/2M, then negate as inv(x)+1 through an XOR mask
  always_comb begin
    m_x1   = {{2{m_q[31]}}, m_q};
    m_x2   = {m_q[31], m_q, 1'b0};
    if (pp_zero) begin
      pp_mag = '0;
    end else if (pp_two) begin
      pp_mag = m_x2;
    end else begin
      pp_mag = m_x1;
    end
    pp_add    = (pp_mag ^ {34{pp_neg}}) + {33'd0, pp_neg};
    upper_sum = acc_q[65:32] + pp_add;
    acc_pre   = {upper_sum, acc_q[31:0]};
    acc_step  = acc_pre >>> 2;
  end

  // Datapath next-state: operand capture, accumulation and step counting
  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (op_clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          acc_d = '0;
          if (op_start) begin
            m_d = multiplicand;
            q_d = {multiplier, 1'b0};
          end
        end
        S_EXEC: begin
          acc_d = acc_step;
          if (cnt_q != LAST_STEP) cnt_d = cnt_q + 4'd1;
        end
        S_DONE: ;
        default: begin
          cnt_d = '0;
          acc_d = '0;
        end
      endcase
    end
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      m_q   <= m_d;
      q_q   <= q_d;
      acc_q <= acc_d;
    end
  end

endmodule
